// File: rtl/m_store_buffer_if.sv
// Store-buffer port bundle: pipeline store/load-forward side and data-memory write side.
interface m_store_buffer_if #(
  parameter int unsigned PTR_W = 2
);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [3:0]       st_be;
  logic [31:0]      st_pc;
  logic             st_ready;
  logic [31:0]      ld_addr;
  logic             fwd_hit;
  logic [3:0]       fwd_be;
  logic [31:0]      fwd_data;
  logic             dm_we;
  logic             dm_ready;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [3:0]       dm_be;
  logic [31:0]      dm_pc;
  logic [PTR_W:0]   count;
  logic             empty;

  // Pipeline / data-memory side
  modport master (
    output st_valid, st_addr, st_data, st_be, st_pc, ld_addr, dm_ready,
    input  st_ready, fwd_hit, fwd_be, fwd_data, dm_we, dm_addr, dm_wdata,
           dm_be, dm_pc, count, empty
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, st_be, st_pc, ld_addr, dm_ready,
    output st_ready, fwd_hit, fwd_be, fwd_data, dm_we, dm_addr, dm_wdata,
           dm_be, dm_pc, count, empty
  );
endinterface

// File: rtl/m_store_buffer.sv
// Posted-write store buffer: in-order FIFO drain to data memory with
// per-byte store-to-load forwarding from all pending entries.
module m_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  m_store_buffer_if.slave   sb
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               st_ready_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  entry_t             head_c;
  logic [3:0]         fwd_be_c;
  logic [31:0]        fwd_data_c;

  // Byte-offset bits are don't-care for word-granular storage and matching
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign st_ready_c = (cnt != FULL_CNT);
  assign empty_c    = (cnt == '0);
  // Zero-enable stores are accepted but never occupy an entry
  assign push_c     = sb.st_valid && st_ready_c && (sb.st_be != 4'b0000);
  assign pop_c      = !empty_c && sb.dm_ready;
  assign head_c     = mem[rd_ptr];

  // Entry payload storage; valid bits gate every read so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{waddr: sb.st_addr[31:2], data: sb.st_data,
                       be: sb.st_be, pc: sb.st_pc};
    end
  end

  // Pointers, occupancy and valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (pop_c) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push_c) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Oldest-to-newest merge so the youngest enabled byte per lane wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_be_c   = '0;
    fwd_data_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (vld[idx] && (mem[idx].waddr == sb.ld_addr[31:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (mem[idx].be[b]) begin
            fwd_be_c[b]           = 1'b1;
            fwd_data_c[8*b +: 8]  = mem[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  assign sb.st_ready = st_ready_c;
  assign sb.empty    = empty_c;
  assign sb.count    = cnt;
  assign sb.fwd_be   = fwd_be_c;
  assign sb.fwd_hit  = |fwd_be_c;
  assign sb.fwd_data = fwd_data_c;

  // Head presentation; zeros while empty so stale payload never leaks out
  assign sb.dm_we    = !empty_c;
  assign sb.dm_addr  = empty_c ? 32'h0 : {head_c.waddr, 2'b00};
  assign sb.dm_wdata = empty_c ? 32'h0 : head_c.data;
  assign sb.dm_be    = empty_c ? 4'h0  : head_c.be;
  assign sb.dm_pc    = empty_c ? 32'h0 : head_c.pc;

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed plan scenarios plus
// randomized traffic against a queue-based reference model.
module tb_m_store_buffer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  m_store_buffer_if #(.PTR_W(2)) sb_if ();

  m_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] drained[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model
  task automatic check_all();
    int          n;
    logic [3:0]  fbe;
    logic [31:0] fdat;
    n    = q.size();
    fbe  = '0;
    fdat = '0;
    foreach (q[k]) begin
      if (q[k].waddr == sb_if.ld_addr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[k].be[b]) begin
            fbe[b]         = 1'b1;
            fdat[8*b +: 8] = q[k].data[8*b +: 8];
          end
        end
      end
    end
    chk("count",    32'(sb_if.count),    32'(n));
    chk("empty",    32'(sb_if.empty),    32'(n == 0));
    chk("st_ready", 32'(sb_if.st_ready), 32'(n < 4));
    chk("dm_we",    32'(sb_if.dm_we),    32'(n != 0));
    chk("dm_addr",  sb_if.dm_addr,  (n != 0) ? {q[0].waddr, 2'b00} : 32'h0);
    chk("dm_wdata", sb_if.dm_wdata, (n != 0) ? q[0].data : 32'h0);
    chk("dm_be",    32'(sb_if.dm_be), (n != 0) ? 32'(q[0].be) : 32'h0);
    chk("dm_pc",    sb_if.dm_pc,    (n != 0) ? q[0].pc : 32'h0);
    chk("fwd_be",   32'(sb_if.fwd_be),   32'(fbe));
    chk("fwd_hit",  32'(sb_if.fwd_hit),  32'(fbe != 4'h0));
    chk("fwd_data", sb_if.fwd_data, fdat);
  endtask

  // Called at negedge with inputs set; checks, advances one clock, returns at negedge
  task automatic step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    #1;
    check_all();
    do_pop  = (q.size() != 0) && sb_if.dm_ready;
    do_push = sb_if.st_valid && (q.size() < 4) && (sb_if.st_be != 4'h0);
    e.waddr = sb_if.st_addr[31:2];
    e.data  = sb_if.st_data;
    e.be    = sb_if.st_be;
    e.pc    = sb_if.st_pc;
    if (do_pop) drained.push_back({q[0].waddr, 2'b00});
    @(posedge clk);
    if (do_pop)  q.delete(0);
    if (do_push) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic [31:0] pc);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
    sb_if.st_be    = be;
    sb_if.st_pc    = pc;
  endtask

  task automatic idle();
    sb_if.st_valid = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge
  task automatic mid_cycle_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_dm_we",    32'(sb_if.dm_we),    32'h0);
    chk("rst_count",    32'(sb_if.count),    32'h0);
    chk("rst_st_ready", 32'(sb_if.st_ready), 32'h1);
    chk("rst_fwd_hit",  32'(sb_if.fwd_hit),  32'h0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.st_be    = '0;
    sb_if.st_pc    = '0;
    sb_if.ld_addr  = '0;
    sb_if.dm_ready = 1'b0;
    @(negedge clk);
    #1;
    check_all();
    chk("reset_dm_addr", sb_if.dm_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single store
    sb_if.dm_ready = 1'b1;
    st(32'h0000_0012, 32'hDEAD_BEEF, 4'hF, 32'h0000_3000);
    step();
    idle();
    #1;
    chk("single_we",    32'(sb_if.dm_we), 32'h1);
    chk("single_addr",  sb_if.dm_addr,    32'h0000_0010);
    chk("single_wdata", sb_if.dm_wdata,   32'hDEAD_BEEF);
    chk("single_pc",    sb_if.dm_pc,      32'h0000_3000);
    step();
    chk("single_count", 32'(sb_if.count), 32'h0);
    chk("single_empty", 32'(sb_if.empty), 32'h1);

    // Fill, reject fifth, drain in order
    sb_if.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(32'(4 * i), 32'h1000 + 32'(i), 4'hF, 32'h100 + 32'(i));
      step();
    end
    chk("fill_count", 32'(sb_if.count),    32'h4);
    chk("fill_ready", 32'(sb_if.st_ready), 32'h0);
    st(32'h10, 32'h5555, 4'hF, 32'h200);
    step();
    idle();
    sb_if.dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_addr", sb_if.dm_addr, 32'(4 * i));
      step();
    end
    chk("drain_empty", 32'(sb_if.empty), 32'h1);

    // Forward merge
    sb_if.dm_ready = 1'b0;
    st(32'h20, 32'h0000_AAAA, 4'b0011, 32'h300);
    step();
    st(32'h20, 32'h00BB_BB00, 4'b0110, 32'h304);
    step();
    idle();
    sb_if.ld_addr = 32'h23;
    #1;
    chk("fwd_hit",  32'(sb_if.fwd_hit), 32'h1);
    chk("fwd_be",   32'(sb_if.fwd_be),  32'h7);
    chk("fwd_data", sb_if.fwd_data,     32'h00BB_BBAA);
    sb_if.ld_addr = 32'h24;
    #1;
    chk("fwd_miss_hit", 32'(sb_if.fwd_hit), 32'h0);
    chk("fwd_miss_be",  32'(sb_if.fwd_be),  32'h0);
    sb_if.dm_ready = 1'b1;
    step();
    step();

    // Full with simultaneous pop
    sb_if.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(32'h40 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 32'h400 + 32'(i));
      step();
    end
    sb_if.dm_ready = 1'b1;
    st(32'h80, 32'hFACE, 4'hF, 32'h500);
    #1 chk("fullpop_ready", 32'(sb_if.st_ready), 32'h0);
    step();
    idle();
    chk("fullpop_count", 32'(sb_if.count),    32'h3);
    chk("fullpop_ready2", 32'(sb_if.st_ready), 32'h1);
    for (int i = 0; i < 3; i++) step();

    // Zero-enable store then six stores interleaved with drain across the wrap
    drained.delete();
    st(32'h900, 32'hBAD0, 4'h0, 32'h600);
    step();
    for (int i = 0; i < 6; i++) begin
      st(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 32'h700 + 32'(i));
      step();
      idle();
      if (i % 2 == 1) step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("wrap_drained", 32'(drained.size()), 32'h6);
    for (int i = 0; i < 6 && i < drained.size(); i++)
      chk("wrap_order", drained[i], 32'h100 + 32'(4 * i));

    // Async reset mid-drain
    sb_if.dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st(32'h200 + 32'(4 * i), 32'hE0 + 32'(i), 4'hF, 32'h800 + 32'(i));
      step();
    end
    idle();
    chk("prereset_count", 32'(sb_if.count), 32'h3);
    mid_cycle_reset();
    sb_if.dm_ready = 1'b1;
    #1 chk("postreset_we", 32'(sb_if.dm_we), 32'h0);
    step();
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      sb_if.st_valid = ($urandom_range(0, 3) != 0);
      sb_if.st_addr  = {25'h0, 3'($urandom_range(0, 7)), 2'($urandom)} << 0;
      sb_if.st_addr  = {sb_if.st_addr[29:0], 2'b00} | 32'($urandom_range(0, 3));
      sb_if.st_data  = $urandom;
      sb_if.st_be    = 4'($urandom_range(0, 15));
      sb_if.st_pc    = $urandom;
      sb_if.dm_ready = ($urandom_range(0, 2) == 0);
      sb_if.ld_addr  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 99) == 0) mid_cycle_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
